// File: rtl/mouse_position_tracker_if.sv
// Packet-in / cursor-out bundle for mouse_position_tracker.
// The slave modport is the tracker; the master modport is whoever drives packets and consumes the cursor.
`timescale 1ns/1ps
interface mouse_position_tracker_if #(
  parameter int POS_W = 10
);
  logic [7:0]       status;
  logic [7:0]       deltaX;
  logic [7:0]       deltaY;
  logic             tx;
  logic [POS_W-1:0] posX;
  logic [POS_W-1:0] posY;
  logic             btn_l;
  logic             btn_r;
  logic             btn_m;
  logic             pos_valid;
  logic             pkt_err;
  logic [7:0]       err_cnt;

  modport slave (
    input  status, deltaX, deltaY, tx,
    output posX, posY, btn_l, btn_r, btn_m, pos_valid, pkt_err, err_cnt
  );

  modport master (
    output status, deltaX, deltaY, tx,
    input  posX, posY, btn_l, btn_r, btn_m, pos_valid, pkt_err, err_cnt
  );
endinterface

// File: rtl/mouse_position_tracker.sv
// PS/2 packet to screen-cursor accumulator: two-stage pipeline, clamped (or wrapped when
// MOUSE_WRAP_EN is defined) to H_RES x V_RES, with saturating error count.
`timescale 1ns/1ps
module mouse_position_tracker #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int POS_W       = 10,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int DELTA_SHIFT = 0
) (
  input  logic                    qzt_clk,
  input  logic                    rst_n,
  mouse_position_tracker_if.slave bus
);
  localparam int SW = POS_W + 2;

  logic                  r_tx_d;
  logic                  r_s1_valid;
  logic                  r_s2_valid;
  logic                  r_pkt_err;
  logic [2:0]            r_s1_btn;
  logic [2:0]            r_btn;
  logic [7:0]            r_err_cnt;

  logic                  w_accept;
  logic                  w_drop;
  logic                  w_load;
  logic [1:0]            w_ovf_cnt;
  logic [8:0]            w_err_sum;
  logic [1:0][POS_W-1:0] w_pos;

  assign w_accept  = bus.tx & ~r_tx_d;
  assign w_drop    = ~bus.status[3];
  assign w_load    = w_accept & ~w_drop;
  assign w_ovf_cnt = {1'b0, bus.status[6]} + {1'b0, bus.status[7]};
  // A dropped packet counts once even if its overflow bits are also set.
  assign w_err_sum = {1'b0, r_err_cnt} + (w_drop ? 9'd1 : {7'd0, w_ovf_cnt});

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_d     <= 1'b1;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_s1_btn   <= 3'b000;
      r_btn      <= 3'b000;
      r_err_cnt  <= 8'd0;
    end else begin
      r_tx_d     <= bus.tx;
      r_s1_valid <= w_load;
      r_pkt_err  <= w_accept & w_drop;
      r_s2_valid <= r_s1_valid;
      if (w_load)
        r_s1_btn <= bus.status[2:0];
      if (w_accept)
        r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      if (r_s1_valid)
        r_btn <= r_s1_btn;
    end
  end

  // Axis 0 is X, axis 1 is Y; Y is negated because PS/2 +Y is up and screen +Y is down.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int LIM  = (gi == 0) ? H_RES : V_RES;
      localparam int INIT = (gi == 0) ? X_INIT : Y_INIT;
      localparam logic signed [SW-1:0] LIM_S  = SW'(LIM);
      localparam logic signed [SW-1:0] LIM_M1 = SW'(LIM - 1);

      logic [7:0]              w_mag;
      logic                    w_sign;
      logic                    w_ovf;
      logic signed [8:0]       w_d9;
      logic signed [8:0]       w_dsh;
      logic signed [SW-1:0]    w_dext;
      logic signed [SW-1:0]    w_dadj;
      logic signed [SW-1:0]    w_sum;
      logic [POS_W-1:0]        w_next;
      logic signed [SW-1:0]    r_s1_d;
      logic [POS_W-1:0]        r_pos;

      assign w_mag  = (gi == 0) ? bus.deltaX : bus.deltaY;
      assign w_sign = bus.status[4+gi];
      assign w_ovf  = bus.status[6+gi];
      assign w_d9   = w_ovf ? 9'sd0 : $signed({w_sign, w_mag});
      assign w_dsh  = w_d9 >>> DELTA_SHIFT;
      assign w_dext = $signed({{(SW-9){w_dsh[8]}}, w_dsh});
      assign w_dadj = (gi == 0) ? w_dext : -w_dext;
      assign w_sum  = $signed({2'b00, r_pos}) + r_s1_d;

      always_comb begin
        w_next = w_sum[POS_W-1:0];
`ifdef MOUSE_WRAP_EN
        if (w_sum[SW-1])
          w_next = POS_W'(w_sum + LIM_S);
        else if (w_sum >= LIM_S)
          w_next = POS_W'(w_sum - LIM_S);
`else
        if (w_sum[SW-1])
          w_next = '0;
        else if (w_sum > LIM_M1)
          w_next = POS_W'(LIM_M1);
`endif
      end

      always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_d <= '0;
          r_pos  <= POS_W'(INIT);
        end else begin
          if (w_load)
            r_s1_d <= w_dadj;
          if (r_s1_valid)
            r_pos <= w_next;
        end
      end

      assign w_pos[gi] = r_pos;
    end
  endgenerate

  assign bus.posX      = w_pos[0];
  assign bus.posY      = w_pos[1];
  assign bus.btn_l     = r_btn[0];
  assign bus.btn_r     = r_btn[1];
  assign bus.btn_m     = r_btn[2];
  assign bus.pos_valid = r_s2_valid;
  assign bus.pkt_err   = r_pkt_err;
  assign bus.err_cnt   = r_err_cnt;
endmodule
